// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync frame generator / serializer pair.
package sync_frame_pkg;

    localparam int unsigned WORD_W    = 10;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic START_BIT_VAL = 1'b0;
    localparam logic STOP_BIT_VAL  = 1'b1;

    // Index of the stop bit; its period ending closes a word.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

    // Line word as sent LSB-first: start bit first, stop bit last.
    typedef struct packed {
        logic              stop;
        logic [DATA_W-1:0] data;
        logic              start;
    } frame_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // A word is well framed when its start and stop bits carry the line levels.
    function automatic logic framing_ok(input frame_word_t w);
        return (w.start == START_BIT_VAL) && (w.stop == STOP_BIT_VAL);
    endfunction

endpackage

// File: rtl/sync_frame_serializer_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] cnt;

    // Tick during the final clock of each bit period.
    assign tick_c = en && (cnt == BAUD_LAST);

    // Clear restarts the period on a shifter load; otherwise wrap at the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/sync_frame_serializer.sv
// Serializes framed 10-bit words LSB-first with a one-word holding buffer
// so consecutive words leave the line with no idle gap.
module sync_frame_serializer
    import sync_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_serial,
    output logic              busy,
    output logic              word_done,
    output logic              frame_err,
    output logic [CNT_W-1:0]  words_sent
);

    ser_state_e           state;
    ser_state_e           state_next;
    frame_word_t          holding;
    frame_word_t          holding_next;
    logic                 holding_full;
    logic                 holding_full_next;
    logic [WORD_W-1:0]    shifter;
    logic [WORD_W-1:0]    shifter_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_next;
    logic                 tx_next;
    logic                 in_ready_next;
    logic                 busy_next;
    logic                 word_done_next;
    logic                 frame_err_next;
    logic [CNT_W-1:0]     words_sent_next;
    logic                 load_c;
    logic                 accept_c;
    logic                 tick_c;

    // Transfer happens only while the holding register is empty.
    assign accept_c = in_valid && in_ready;

    // Bit-period timer, restarted whenever a new word enters the shifter.
    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (load_c),
        .en      (state == SHIFT),
        .tick_c  (tick_c)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_next        = state;
        holding_next      = holding;
        holding_full_next = holding_full;
        shifter_next      = shifter;
        bit_cnt_next      = bit_cnt;
        tx_next           = tx_serial;
        words_sent_next   = words_sent;
        word_done_next    = 1'b0;
        frame_err_next    = 1'b0;
        load_c            = 1'b0;

        case (state)
            IDLE: begin
                tx_next = STOP_BIT_VAL;
                if (holding_full) begin
                    load_c = 1'b1;
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    if (bit_cnt == LAST_BIT) begin
                        word_done_next  = 1'b1;
                        words_sent_next = words_sent + CNT_W'(1);
                        if (holding_full) begin
                            load_c = 1'b1;
                        end else begin
                            state_next = IDLE;
                            tx_next    = STOP_BIT_VAL;
                        end
                    end else begin
                        shifter_next = {STOP_BIT_VAL, shifter[WORD_W-1:1]};
                        tx_next      = shifter[1];
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = STOP_BIT_VAL;
            end
        endcase

        // Moving the held word into the shifter puts its start bit on the line next cycle.
        if (load_c) begin
            shifter_next      = holding;
            tx_next           = holding.start;
            bit_cnt_next      = '0;
            holding_full_next = 1'b0;
            state_next        = SHIFT;
        end

        // Badly framed words are dropped and flagged; the buffer stays empty.
        if (accept_c) begin
            if (framing_ok(frame_word_t'(in_word))) begin
                holding_next      = frame_word_t'(in_word);
                holding_full_next = 1'b1;
            end else begin
                frame_err_next = 1'b1;
            end
        end

        in_ready_next = ~holding_full_next;
        busy_next     = (state_next == SHIFT) || holding_full_next;
    end

    // State and registered outputs; reset forces the line high at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            holding      <= '0;
            holding_full <= 1'b0;
            shifter      <= '1;
            bit_cnt      <= '0;
            tx_serial    <= STOP_BIT_VAL;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            word_done    <= 1'b0;
            frame_err    <= 1'b0;
            words_sent   <= '0;
        end else begin
            state        <= state_next;
            holding      <= holding_next;
            holding_full <= holding_full_next;
            shifter      <= shifter_next;
            bit_cnt      <= bit_cnt_next;
            tx_serial    <= tx_next;
            in_ready     <= in_ready_next;
            busy         <= busy_next;
            word_done    <= word_done_next;
            frame_err    <= frame_err_next;
            words_sent   <= words_sent_next;
        end
    end

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Bench for sync_frame_serializer: randomized words against a timing model of the line.
module tb_sync_frame_serializer;
    import sync_frame_pkg::*;

    localparam int unsigned CPB   = 4;
    localparam int unsigned CW    = 4;
    localparam int          WCYC  = 10 * CPB;
    localparam int          LOG_N = 8192;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic              tx_serial;
    logic              busy;
    logic              word_done;
    logic              frame_err;
    logic [CW-1:0]     words_sent;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    sync_frame_serializer #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_serial  (tx_serial),
        .busy       (busy),
        .word_done  (word_done),
        .frame_err  (frame_err),
        .words_sent (words_sent)
    );

    // Per-cycle log of outputs, sampled 1 time unit after each rising edge.
    logic          tx_log   [LOG_N];
    logic          done_log [LOG_N];
    logic          ferr_log [LOG_N];
    logic          busy_log [LOG_N];
    logic          rdy_log  [LOG_N];
    logic [CW-1:0] ws_log   [LOG_N];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < LOG_N) begin
            tx_log[cyc]   = tx_serial;
            done_log[cyc] = word_done;
            ferr_log[cyc] = frame_err;
            busy_log[cyc] = busy;
            rdy_log[cyc]  = in_ready;
            ws_log[cyc]   = words_sent;
        end
    end

    // Line model: a good word accepted at edge a starts at max(a+1, end of previous word)
    // and occupies 10*CPB samples; a bad word only raises frame_err at its accept sample.
    int                m_acc   [$];
    int                m_start [$];
    int                m_end   [$];
    logic [WORD_W-1:0] m_word  [$];
    int                m_bad   [$];
    int                m_last_end = 0;

    function automatic void model_reset();
        m_acc.delete();
        m_start.delete();
        m_end.delete();
        m_word.delete();
        m_bad.delete();
        m_last_end = 0;
    endfunction

    function automatic void model_accept(input logic [WORD_W-1:0] w, input int a);
        int s;
        if (w[0] == 1'b0 && w[WORD_W-1] == 1'b1) begin
            s = (a + 1 > m_last_end) ? a + 1 : m_last_end;
            m_acc.push_back(a);
            m_start.push_back(s);
            m_end.push_back(s + WCYC);
            m_word.push_back(w);
            m_last_end = s + WCYC;
        end else begin
            m_bad.push_back(a);
        end
    endfunction

    task automatic drive_word(input logic [WORD_W-1:0] w);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drive_word: in_ready=%b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
        end else begin
            in_word  = w;
            in_valid = 1'b1;
            model_accept(w, cyc + 1);
        end
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = WORD_W'($urandom);
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_line_done();
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < m_last_end + 2 && cyc < LOG_N - 4) @(negedge clk);
    endtask

    // Compare the logged window against the model, one check per signal.
    task automatic check_window(input string name, input int from, input int to);
        int bad_tx = -1, bad_dn = -1, bad_bz = -1, bad_fe = -1, bad_ws = -1;
        logic etx, edn, ebz, efe;
        int   ews;
        logic [WORD_W-1:0] w;
        for (int k = from; k <= to && k < LOG_N; k++) begin
            etx = 1'b1; edn = 1'b0; ebz = 1'b0; efe = 1'b0; ews = -1;
            for (int i = 0; i < m_start.size(); i++) begin
                if (k >= m_start[i] && k < m_end[i]) begin
                    w   = m_word[i];
                    etx = w[(k - m_start[i]) / CPB];
                end
                if (k == m_end[i]) begin
                    edn = 1'b1;
                    ews = (i + 1) % (1 << CW);
                end
                if (k >= m_acc[i] && k < m_end[i]) ebz = 1'b1;
            end
            for (int j = 0; j < m_bad.size(); j++) if (k == m_bad[j]) efe = 1'b1;
            if (bad_tx < 0 && tx_log[k] !== etx) bad_tx = k;
            if (bad_dn < 0 && done_log[k] !== edn) bad_dn = k;
            if (bad_bz < 0 && busy_log[k] !== ebz) bad_bz = k;
            if (bad_fe < 0 && ferr_log[k] !== efe) bad_fe = k;
            if (bad_ws < 0 && ews >= 0 && int'(ws_log[k]) != ews) bad_ws = k;
        end
        checks += 5;
        if (bad_tx >= 0) begin
            errors++;
            $display("FAIL %s tx_serial: cycle %0d got %b", name, bad_tx, tx_log[bad_tx]);
        end
        if (bad_dn >= 0) begin
            errors++;
            $display("FAIL %s word_done: cycle %0d got %b", name, bad_dn, done_log[bad_dn]);
        end
        if (bad_bz >= 0) begin
            errors++;
            $display("FAIL %s busy: cycle %0d got %b", name, bad_bz, busy_log[bad_bz]);
        end
        if (bad_fe >= 0) begin
            errors++;
            $display("FAIL %s frame_err: cycle %0d got %b", name, bad_fe, ferr_log[bad_fe]);
        end
        if (bad_ws >= 0) begin
            errors++;
            $display("FAIL %s words_sent: cycle %0d got %0d", name, bad_ws, ws_log[bad_ws]);
        end
    endtask

    task automatic check_count(input string name, input logic [CW-1:0] required);
        checks++;
        if (words_sent !== required) begin
            errors++;
            $display("FAIL %s words_sent: got %0d, required %0d", name, words_sent, required);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({tx_serial, in_ready, busy, word_done, frame_err} !== 5'b11000 || words_sent !== '0) begin
            errors++;
            $display("FAIL %s: tx=%b rdy=%b busy=%b done=%b ferr=%b ws=%0d, required 1 1 0 0 0 0",
                     name, tx_serial, in_ready, busy, word_done, frame_err, words_sent);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("after_release");
    endtask

    task automatic test_single_word();
        int from = cyc + 1;
        drive_word(10'h34A);
        wait_line_done();
        check_window("single_word", from, cyc);
        check_count("single_word", CW'(m_start.size()));
    endtask

    task automatic test_bad_framing();
        int from = cyc + 1;
        drive_word(10'h0FF);
        drive_word(10'h2FE);
        wait_line_done();
        check_window("bad_framing", from, cyc);
        checks++;
        if (m_bad.size() != 1) begin
            errors++;
            $display("FAIL bad_framing model: bad words %0d, required 1", m_bad.size());
        end
    endtask

    task automatic test_back_to_back();
        int from = cyc + 1;
        int n0   = m_start.size();
        drive_word(10'h34A);
        drive_word(10'h202);
        wait_line_done();
        check_window("back_to_back", from, cyc);
        checks++;
        if (m_start[n0 + 1] != m_end[n0]) begin
            errors++;
            $display("FAIL back_to_back gap: second start %0d, required %0d", m_start[n0 + 1], m_end[n0]);
        end
    endtask

    task automatic test_burst();
        int from = cyc + 1;
        int n0   = m_start.size();
        int ones = 0;
        for (int i = 0; i < 16; i++) drive_word({STOP_BIT_VAL, 8'($urandom), START_BIT_VAL});
        wait_line_done();
        check_window("burst", from, cyc);
        for (int k = m_acc[n0]; k <= m_acc[n0 + 15]; k++) if (rdy_log[k] === 1'b1) ones++;
        checks++;
        if (ones != 15) begin
            errors++;
            $display("FAIL burst in_ready: high for %0d cycles, required 15", ones);
        end
        check_count("burst", CW'(m_start.size()));
    endtask

    task automatic test_random();
        int from = cyc + 1;
        logic [WORD_W-1:0] w;
        for (int i = 0; i < 20; i++) begin
            w = {STOP_BIT_VAL, 8'($urandom), START_BIT_VAL};
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) w[0] = 1'b1;
                else w[WORD_W-1] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 60));
            drive_word(w);
        end
        wait_line_done();
        check_window("random", from, cyc);
    endtask

    task automatic test_reset_mid_word();
        int s;
        int from;
        drive_word(10'h34A);
        s = m_start[m_start.size() - 1];
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < s + 5 * CPB + 1) @(negedge clk);
        checks++;
        if (tx_serial !== 1'b0) begin
            errors++;
            $display("FAIL mid_word bit5: tx=%b, required 0", tx_serial);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_word_async");
        @(negedge clk);
        check_reset_outputs("mid_word_held");
        reset_n = 1'b1;
        model_reset();
        from = cyc + 1;
        drive_word(10'h34A);
        wait_line_done();
        check_window("after_reset", from, cyc);
        check_count("after_reset", CW'(1));
    endtask

    task automatic test_wrap();
        int from;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        from = cyc + 1;
        for (int i = 0; i < 17; i++) drive_word({STOP_BIT_VAL, 8'($urandom), START_BIT_VAL});
        wait_line_done();
        check_window("wrap", from, cyc);
        check_count("wrap", CW'(1));
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_framing();
        test_back_to_back();
        test_burst();
        test_random();
        test_reset_mid_word();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
